// File: rtl/jbi_ncio_prtq_ctl.sv
// NCIO PRTQ control: drives a 16-entry two-port array and holds read data in a 2-entry output stage.
// Optional macro JBI_PRTQ_OVFL_CHK_EN enables the sticky prtq_ovfl error on enqueue-while-full.
module jbi_ncio_prtq_ctl #(
  parameter int unsigned WIDTH      = 146,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_vld,
  input  logic [WIDTH-1:0]      enq_data,
  output logic                  enq_rdy,
  output logic                  deq_vld,
  output logic [WIDTH-1:0]      deq_data,
  input  logic                  deq_rdy,
  output logic                  prtq_csn_wr,
  output logic [ADDR_WIDTH-1:0] prtq_waddr,
  output logic [WIDTH-1:0]      prtq_wdata,
  output logic                  prtq_csn_rd,
  output logic [ADDR_WIDTH-1:0] prtq_raddr,
  input  logic [WIDTH-1:0]      prtq_rdata,
  output logic [4:0]            prtq_level,
  output logic                  prtq_ovfl
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [CW-1:0]         arr_cnt, arr_cnt_n;
  logic                  rd_inflight;
  logic [1:0]            out_cnt, out_cnt_n;
  logic [WIDTH-1:0]      head, tail, head_n, tail_n;
  logic                  enq, deq, rd;

  // Handshakes and read issue; reads only see entries already counted in the registered arr_cnt
  assign enq_rdy     = ~rst & (arr_cnt != CW'(DEPTH));
  assign enq         = enq_vld & enq_rdy;
  assign deq_vld     = ~rst & (out_cnt != 2'd0);
  assign deq         = deq_vld & deq_rdy;
  assign rd          = ~rst & (arr_cnt != '0) &
                       (({1'b0, out_cnt} + {2'b0, rd_inflight}) < (3'd2 + {2'b0, deq}));

  assign prtq_csn_wr = ~enq;
  assign prtq_waddr  = wptr;
  assign prtq_wdata  = enq_data;
  assign prtq_csn_rd = ~rd;
  assign prtq_raddr  = rptr;
  assign deq_data    = head;

  // Next-state for counters and the head/tail output stage
  always_comb begin
    arr_cnt_n = arr_cnt + CW'(enq) - CW'(rd);
    out_cnt_n = out_cnt + 2'(rd_inflight) - 2'(deq);
    head_n    = head;
    tail_n    = tail;
    if (deq && rd_inflight) begin
      if (out_cnt == 2'd2) begin
        head_n = tail;
        tail_n = prtq_rdata;
      end else begin
        head_n = prtq_rdata;
      end
    end else if (deq) begin
      head_n = tail;
    end else if (rd_inflight) begin
      if (out_cnt == 2'd0) head_n = prtq_rdata;
      else                 tail_n = prtq_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      arr_cnt     <= '0;
      rd_inflight <= 1'b0;
      out_cnt     <= 2'd0;
      head        <= '0;
      tail        <= '0;
      prtq_level  <= 5'd0;
    end else begin
      if (enq) wptr <= wptr + ADDR_WIDTH'(1);
      if (rd)  rptr <= rptr + ADDR_WIDTH'(1);
      arr_cnt     <= arr_cnt_n;
      rd_inflight <= rd;
      out_cnt     <= out_cnt_n;
      head        <= head_n;
      tail        <= tail_n;
      prtq_level  <= 5'(arr_cnt_n) + 5'(rd) + 5'(out_cnt_n);
    end
  end

`ifdef JBI_PRTQ_OVFL_CHK_EN
  // Sticky until reset; the offered entry is dropped because enq_rdy is low
  always_ff @(posedge clk) begin
    if (rst)                                       prtq_ovfl <= 1'b0;
    else if (enq_vld && (arr_cnt == CW'(DEPTH)))   prtq_ovfl <= 1'b1;
  end
`else
  assign prtq_ovfl = 1'b0;
`endif

endmodule

// File: tb/tb_jbi_ncio_prtq_ctl.sv
// Scoreboard bench for jbi_ncio_prtq_ctl with a behavioural 16-entry array (1-cycle read latency).
module tb_jbi_ncio_prtq_ctl;

  localparam int unsigned WIDTH = 146;
  localparam int unsigned AW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enq_vld;
  logic [WIDTH-1:0] enq_data;
  logic             enq_rdy;
  logic             deq_vld;
  logic [WIDTH-1:0] deq_data;
  logic             deq_rdy;
  logic             prtq_csn_wr;
  logic [AW-1:0]    prtq_waddr;
  logic [WIDTH-1:0] prtq_wdata;
  logic             prtq_csn_rd;
  logic [AW-1:0]    prtq_raddr;
  logic [WIDTH-1:0] prtq_rdata;
  logic [4:0]       prtq_level;
  logic             prtq_ovfl;

  jbi_ncio_prtq_ctl dut (
    .clk(clk), .rst(rst),
    .enq_vld(enq_vld), .enq_data(enq_data), .enq_rdy(enq_rdy),
    .deq_vld(deq_vld), .deq_data(deq_data), .deq_rdy(deq_rdy),
    .prtq_csn_wr(prtq_csn_wr), .prtq_waddr(prtq_waddr), .prtq_wdata(prtq_wdata),
    .prtq_csn_rd(prtq_csn_rd), .prtq_raddr(prtq_raddr), .prtq_rdata(prtq_rdata),
    .prtq_level(prtq_level), .prtq_ovfl(prtq_ovfl)
  );

  always #5 clk = ~clk;

  // Array model: write and read on the same clock, read data valid the following cycle
  logic [WIDTH-1:0] mem [16];
  always @(posedge clk) begin
    if (!prtq_csn_wr) mem[prtq_waddr] <= prtq_wdata;
    if (!prtq_csn_rd) prtq_rdata <= mem[prtq_raddr];
  end

  int n_chk  = 0;
  int n_pass = 0;
  int deq_cnt = 0;
  logic [WIDTH-1:0] sb [$];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: push accepted entries, pop and compare on every dequeue
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (enq_vld && enq_rdy) sb.push_back(enq_data);
      if (deq_vld && deq_rdy) begin
        deq_cnt++;
        if (sb.size() == 0) check("deq_unexpected", deq_data, '1);
        else check("deq_data", deq_data, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string name);
    deq_rdy = 1'b1;
    for (int i = 0; i < budget && prtq_level != 5'd0; i++) tick();
    check(name, WIDTH'(prtq_level), '0);
  endtask

  int d0;
  logic exp_ovfl;

  initial begin
`ifdef JBI_PRTQ_OVFL_CHK_EN
    exp_ovfl = 1'b1;
`else
    exp_ovfl = 1'b0;
`endif
    rst = 1'b1; enq_vld = 1'b0; enq_data = '0; deq_rdy = 1'b0;
    repeat (3) tick();
    check("rst_enq_rdy", WIDTH'(enq_rdy), '0);
    check("rst_deq_vld", WIDTH'(deq_vld), '0);
    check("rst_csn_wr", WIDTH'(prtq_csn_wr), 1);
    check("rst_csn_rd", WIDTH'(prtq_csn_rd), 1);
    check("rst_level", WIDTH'(prtq_level), '0);
    check("rst_ovfl", WIDTH'(prtq_ovfl), '0);
    rst = 1'b0;
    tick();
    check("enq_rdy_after_rst", WIDTH'(enq_rdy), 1);

    // Single entry latency
    enq_vld = 1'b1; enq_data = WIDTH'(1); deq_rdy = 1'b1; #1;
    check("t1_csn_wr", WIDTH'(prtq_csn_wr), '0);
    check("t1_waddr", WIDTH'(prtq_waddr), '0);
    tick(); enq_vld = 1'b0; #1;
    check("t1_csn_rd", WIDTH'(prtq_csn_rd), '0);
    check("t1_raddr", WIDTH'(prtq_raddr), '0);
    check("t1_level_n1", WIDTH'(prtq_level), 1);
    tick();
    check("t1_deq_vld_n2", WIDTH'(deq_vld), '0);
    check("t1_level_n2", WIDTH'(prtq_level), 1);
    tick();
    check("t1_deq_vld_n3", WIDTH'(deq_vld), 1);
    check("t1_level_n3", WIDTH'(prtq_level), 1);
    tick();
    check("t1_level_n4", WIDTH'(prtq_level), '0);

    // Fill to 18 with consumer stalled; write address wraps 15 -> 0
    deq_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      enq_vld = 1'b1; enq_data = WIDTH'(32'h100 + i); #1;
      check("t2_waddr", WIDTH'(prtq_waddr), WIDTH'((1 + i) % 16));
      tick();
    end
    enq_vld = 1'b0;
    repeat (4) tick();
    check("t2_level16", WIDTH'(prtq_level), 16);
    for (int i = 0; i < 2; i++) begin
      enq_vld = 1'b1; enq_data = WIDTH'(32'h110 + i);
      tick();
    end
    enq_vld = 1'b0;
    tick();
    check("t2_level18", WIDTH'(prtq_level), 18);
    check("t2_enq_rdy_full", WIDTH'(enq_rdy), '0);

    // Enqueue attempt while full
    enq_vld = 1'b1; enq_data = WIDTH'(32'hBAD);
    tick(); enq_vld = 1'b0;
    tick();
    check("ovfl", WIDTH'(prtq_ovfl), WIDTH'(exp_ovfl));
    tick();
    check("ovfl_sticky", WIDTH'(prtq_ovfl), WIDTH'(exp_ovfl));
    check("ovfl_level", WIDTH'(prtq_level), 18);
    drain(100, "t2_drain_level");

    // Back-to-back streaming: one dequeue per cycle
    deq_rdy = 1'b1; d0 = deq_cnt;
    for (int i = 0; i < 40; i++) begin
      enq_vld = 1'b1; enq_data = WIDTH'(i);
      tick();
    end
    enq_vld = 1'b0;
    repeat (3) tick();
    check("t3_deq_count", WIDTH'(deq_cnt - d0), 40);
    check("t3_level", WIDTH'(prtq_level), '0);

    // Consumer toggling 1010 with reads in flight
    d0 = deq_cnt;
    for (int i = 0; i < 12; i++) begin
      enq_vld = 1'b1; enq_data = WIDTH'(32'h200 + i); deq_rdy = (i % 2 == 0);
      tick();
    end
    enq_vld = 1'b0;
    for (int i = 0; i < 60 && prtq_level != 5'd0; i++) begin
      deq_rdy = ~deq_rdy;
      tick();
    end
    check("t4_level", WIDTH'(prtq_level), '0);
    check("t4_deq_count", WIDTH'(deq_cnt - d0), 12);

    // Reset with entries queued and a read in flight
    deq_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq_vld = 1'b1; enq_data = WIDTH'(32'h300 + i);
      tick();
    end
    enq_vld = 1'b0;
    repeat (3) tick();
    check("t5_level5", WIDTH'(prtq_level), 5);
    deq_rdy = 1'b1;
    tick();
    deq_rdy = 1'b0; rst = 1'b1;
    check("t5_level_inflight", WIDTH'(prtq_level), 4);
    tick();
    rst = 1'b0; #1;
    check("t5_deq_vld", WIDTH'(deq_vld), '0);
    check("t5_level", WIDTH'(prtq_level), '0);
    check("t5_enq_rdy", WIDTH'(enq_rdy), 1);
    check("t5_ovfl_cleared", WIDTH'(prtq_ovfl), '0);
    enq_vld = 1'b1; enq_data = WIDTH'(32'h400); #1;
    check("t5_waddr", WIDTH'(prtq_waddr), '0);
    check("t5_csn_wr", WIDTH'(prtq_csn_wr), '0);
    tick();
    enq_vld = 1'b0;
    drain(20, "t5_drain_level");
    tick();
    check("sb_empty", WIDTH'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
